uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encodings, register map, status layout.
package uart_pkg;

   // Receive FSM states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Register offsets within the device window (addr[3:0])
   localparam logic [3:0] ADDR_RX_DATA = 4'h4;
   localparam logic [3:0] ADDR_RX_STAT = 4'h5;

   // Status register bit positions
   localparam int unsigned STAT_NOT_EMPTY = 0;
   localparam int unsigned STAT_FULL      = 1;
   localparam int unsigned STAT_FRAME_ERR = 2;
   localparam int unsigned STAT_OVERRUN   = 3;

   // Oversampling geometry
   localparam int unsigned TICKS_PER_BIT = 16;
   localparam int unsigned TICK_MID      = 8;
   localparam int unsigned DATA_BITS     = 8;
   localparam int unsigned SMP_W         = 4;
   localparam int unsigned BIT_W         = 3;

   // Status register payload; field order matches the STAT_* bit positions
   typedef struct packed {
      logic overrun;
      logic frame_err;
      logic full;
      logic not_empty;
   } rx_status_t;

   // Zero-extend the status payload to a bus word
   function automatic logic [31:0] status_word(input rx_status_t s);
      return {28'b0, s};
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, wrap-bit pointers, head visible combinationally.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  mem [DEPTH];
   logic        wr_en_c;
   logic        rd_en_c;

   // A push into a full FIFO is accepted only when a pop frees the head slot this cycle
   assign wr_en_c = push & (~full | pop);
   assign rd_en_c = pop & ~empty;

   // Pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en_c) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 deserializer with receive FIFO and bus registers.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DIV        = 78,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [2:0]  write_enable,
   input  logic [23:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        uart_rxd,
   output logic        rx_irq
);

   localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick_c;

   logic [1:0]        rxd_sync;
   logic [1:0]        sync_fill;
   logic              rxd_s;

   rx_state_t         state;
   logic [SMP_W-1:0]  smp_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [7:0]        shreg;
   logic              armed;

   logic              stop_sample_c;
   logic              push_c;
   logic              frame_set_c;
   logic              overrun_set_c;

   logic [3:0]        addr_lo;
   logic              sel_data_c;
   logic              sel_stat_c;
   logic              pop_c;
   logic              clr_c;

   logic              overrun;
   logic              frame_err;
   logic [7:0]        fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   rx_status_t        status;
   logic [31:0]       rd_mux_c;
   logic              unused_bits;

   // Free-running oversample tick generator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else if (tick_c) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TICK_W'(1);
   end

   assign tick_c = (tick_cnt == TICK_W'(DIV - 1));

   // Two-flop line synchronizer; sync_fill marks when rxd_s reflects the real line after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_sync  <= 2'b11;
         sync_fill <= 2'b00;
      end else begin
         rxd_sync  <= {rxd_sync[0], uart_rxd};
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   assign rxd_s = rxd_sync[1];

   // Frame FSM; armed requires a genuine high level before a start edge is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RX_IDLE;
         smp_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         armed   <= 1'b0;
      end else begin
         case (state)
            RX_IDLE: begin
               if (sync_fill[1] && rxd_s) armed <= 1'b1;
               if (tick_c && armed && !rxd_s) begin
                  state   <= RX_START;
                  smp_cnt <= '0;
                  armed   <= 1'b0;
               end
            end
            RX_START: begin
               if (tick_c) begin
                  if (smp_cnt == SMP_W'(TICK_MID - 1)) begin
                     smp_cnt <= '0;
                     if (!rxd_s) begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                     end else begin
                        state <= RX_IDLE;
                     end
                  end else begin
                     smp_cnt <= smp_cnt + SMP_W'(1);
                  end
               end
            end
            RX_DATA: begin
               if (tick_c) begin
                  if (smp_cnt == SMP_W'(TICKS_PER_BIT - 1)) begin
                     smp_cnt <= '0;
                     shreg   <= {rxd_s, shreg[7:1]};
                     if (bit_cnt == BIT_W'(DATA_BITS - 1)) state <= RX_STOP;
                     else bit_cnt <= bit_cnt + BIT_W'(1);
                  end else begin
                     smp_cnt <= smp_cnt + SMP_W'(1);
                  end
               end
            end
            RX_STOP: begin
               if (tick_c) begin
                  if (smp_cnt == SMP_W'(TICKS_PER_BIT - 1)) begin
                     smp_cnt <= '0;
                     state   <= RX_IDLE;
                  end else begin
                     smp_cnt <= smp_cnt + SMP_W'(1);
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   // Stop-bit sample decides push versus framing error in the same cycle
   assign stop_sample_c = tick_c && (state == RX_STOP) && (smp_cnt == SMP_W'(TICKS_PER_BIT - 1));
   assign push_c        = stop_sample_c && rxd_s;
   assign frame_set_c   = stop_sample_c && !rxd_s;

   // Bus decode
   assign addr_lo    = addr[3:0];
   assign sel_data_c = en && (addr_lo == ADDR_RX_DATA);
   assign sel_stat_c = en && (addr_lo == ADDR_RX_STAT);
   assign pop_c      = sel_data_c && (write_enable == 3'b000) && !fifo_empty;
   assign clr_c      = sel_stat_c && write_enable[2];

   // A full FIFO being popped in the same cycle still has room for the new byte
   assign overrun_set_c = push_c && fifo_full && !pop_c;

   // Sticky error flags; a set in the same cycle as a clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (overrun_set_c) overrun <= 1'b1;
         else if (clr_c && data_in[STAT_OVERRUN]) overrun <= 1'b0;
         if (frame_set_c) frame_err <= 1'b1;
         else if (clr_c && data_in[STAT_FRAME_ERR]) frame_err <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (shreg),
      .pop       (pop_c),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign status.overrun   = overrun;
   assign status.frame_err = frame_err;
   assign status.full      = fifo_full;
   assign status.not_empty = !fifo_empty;

   // Read mux; the bus is released outside the two decoded registers
   always_comb begin
      rd_mux_c = '0;
      if (sel_data_c) rd_mux_c = fifo_empty ? 32'b0 : {24'b0, fifo_head};
      else if (sel_stat_c) rd_mux_c = status_word(status);
   end

   assign data_out = (sel_data_c || sel_stat_c) ? rd_mux_c : 32'bz;
   assign rx_irq   = !fifo_empty || overrun || frame_err;

   assign unused_bits = ^{addr[23:4], data_in[31:4], data_in[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DIV=4 (64 clk per bit) and a 4-entry FIFO.
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [2:0]  write_enable = 3'b000;
   logic [23:0] addr = 24'h0;
   logic [31:0] data_in = 32'h0;
   wire  [31:0] data_out;
   logic        uart_rxd = 1'b1;
   logic        rx_irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   uart_rx #(
      .DIV        (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .write_enable (write_enable),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_out),
      .uart_rxd     (uart_rxd),
      .rx_irq       (rx_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic [3:0]  exp_stat;
      logic [31:0] exp_rd;
      logic [31:0] clr;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame starting at the current time
   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rxd = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (BIT_CLK) @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      en = 1'b1; write_enable = 3'b000; addr = {20'h0, a};
      #1 d = data_out;
      @(negedge clk);
      en = 1'b0; addr = 24'h0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      en = 1'b1; write_enable = 3'b100; addr = {20'h0, a}; data_in = d;
      @(negedge clk);
      en = 1'b0; write_enable = 3'b000; addr = 24'h0; data_in = 32'h0;
   endtask

   task automatic align4();
      @(negedge clk);
      while (cyc % 4 != 0) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      int          s0, s1, d_push;
      logic        calib_ok;

      vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_stat: 4'h1, exp_rd: 32'h0000_00A5, clr: 32'h0};
      vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_stat: 4'h4, exp_rd: 32'h0,         clr: 32'h4};
      vecs[2] = '{data: 8'h00, stop: 1'b1, exp_stat: 4'h1, exp_rd: 32'h0000_0000, clr: 32'h0};
      vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_stat: 4'h1, exp_rd: 32'h0000_00FF, clr: 32'h0};
      vecs[4] = '{data: 8'h81, stop: 1'b0, exp_stat: 4'h4, exp_rd: 32'h0,         clr: 32'hC};

      // Reset state
      idle(3);
      rst_n = 1'b1;
      idle(10);
      bus_read(4'h5, rd); check("reset_stat", rd, 32'h0);
      check("reset_irq", {31'b0, rx_irq}, 32'h0);
      bus_read(4'h4, rd); check("reset_data", rd, 32'h0);

      // Single-frame vectors
      for (int i = 0; i < 5; i++) begin
         send_byte(vecs[i].data, vecs[i].stop);
         idle(16);
         bus_read(4'h5, rd); check($sformatf("vec%0d_stat", i), rd, {28'b0, vecs[i].exp_stat});
         check($sformatf("vec%0d_irq", i), {31'b0, rx_irq}, {31'b0, (vecs[i].exp_stat != 4'h0)});
         bus_read(4'h4, rd); check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
         bus_read(4'h5, rd); check($sformatf("vec%0d_stat_pop", i), rd, {28'b0, vecs[i].exp_stat[3:2], 2'b00});
         bus_write(4'h5, vecs[i].clr);
         bus_read(4'h5, rd); check($sformatf("vec%0d_stat_clr", i), rd, 32'h0);
         check($sformatf("vec%0d_irq_clr", i), {31'b0, rx_irq}, 32'h0);
      end

      // Short low glitch is rejected, then a real frame still decodes
      idle(20);
      uart_rxd = 1'b0;
      idle(20);
      uart_rxd = 1'b1;
      idle(800);
      bus_read(4'h5, rd); check("glitch_stat", rd, 32'h0);
      send_byte(8'h5A, 1'b1);
      idle(16);
      bus_read(4'h4, rd); check("glitch_next_data", rd, 32'h0000_005A);

      // Five back-to-back frames overrun a 4-entry FIFO
      idle(20);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      idle(16);
      bus_read(4'h5, rd); check("ovr_stat", rd, 32'hB);
      for (int i = 1; i <= 4; i++) begin
         bus_read(4'h4, rd); check($sformatf("ovr_data%0d", i), rd, 32'(i));
      end
      bus_read(4'h5, rd); check("ovr_stat_drain", rd, 32'h8);
      bus_write(4'h5, 32'h8);
      bus_read(4'h5, rd); check("ovr_stat_clr", rd, 32'h0);

      // Find the push cycle relative to a tick-aligned frame start
      idle(40);
      align4();
      s0 = cyc;
      calib_ok = 1'b0;
      d_push = 0;
      fork
         send_byte(8'h77, 1'b1);
         begin
            en = 1'b1; write_enable = 3'b000; addr = 24'h5;
            for (int k = 0; k < 1200 && !calib_ok; k++) begin
               @(negedge clk);
               #1;
               if (data_out[0] === 1'b1) begin
                  calib_ok = 1'b1;
                  d_push = cyc - s0;
               end
            end
            en = 1'b0; addr = 24'h0;
         end
      join
      check("calib_found", {31'b0, calib_ok}, 32'h1);
      idle(16);
      bus_read(4'h4, rd); check("calib_data", rd, 32'h0000_0077);

      // Pop on the exact cycle of a push into a full FIFO
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
      idle(16);
      bus_read(4'h5, rd); check("pp_full_stat", rd, 32'h3);
      idle(40);
      align4();
      s1 = cyc;
      fork
         send_byte(8'h66, 1'b1);
         begin
            if (calib_ok) begin
               while (cyc != s1 + d_push - 1) @(negedge clk);
               en = 1'b1; write_enable = 3'b000; addr = 24'h4;
               #1 check("pp_pop_head", data_out, 32'h0000_0011);
               @(negedge clk);
               en = 1'b0; addr = 24'h0;
            end
         end
      join
      idle(16);
      bus_read(4'h5, rd); check("pp_stat", rd, 32'h3);
      for (int i = 0; i < 3; i++) begin
         bus_read(4'h4, rd); check($sformatf("pp_data%0d", i), rd, 32'h12 + 32'(i));
      end
      bus_read(4'h4, rd); check("pp_last", rd, 32'h0000_0066);
      bus_read(4'h5, rd); check("pp_stat_empty", rd, 32'h0);

      // Reset during bit 4 abandons the frame; the next frame is received
      idle(40);
      fork
         send_byte(8'h81, 1'b1);
         begin
            repeat (BIT_CLK * 5 + 20) @(negedge clk);
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      idle(16);
      bus_read(4'h5, rd); check("rst_mid_stat", rd, 32'h0);
      check("rst_mid_irq", {31'b0, rx_irq}, 32'h0);
      send_byte(8'h42, 1'b1);
      idle(16);
      bus_read(4'h5, rd); check("rst_next_stat", rd, 32'h1);
      bus_read(4'h4, rd); check("rst_next_data", rd, 32'h0000_0042);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
